mem_port_arbiter: RTL and testbench

Shares the single-ported data memory file between two requesters: the fetch stage (instruction reads) and the MEM stage (loads and stores).
- Each requester uses a level-held request / single-cycle ack handshake.
- One access is in flight at a time; the memory has a fixed access latency.
- The block generates per-requester stall signals so the pipeline freezes until its access completes.
- It sits between the fetch and memory stages and the memoryFile instance.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_arb_select.sv | 26 ++
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared constants for the memory-port arbiter: access size codes, read/write
// encoding, requester ids and the arbiter FSM state type.
package mem_pkg;

  localparam logic [2:0] SZ_B = 3'd0;
  localparam logic [2:0] SZ_H = 3'd1;
  localparam logic [2:0] SZ_W = 3'd2;
  localparam logic [2:0] SZ_D = 3'd3;

  localparam logic R_W_READ  = 1'b0;
  localparam logic R_W_WRITE = 1'b1;

  localparam logic REQ_FE  = 1'b0;
  localparam logic REQ_MEM = 1'b1;

  // Access-cycle counter width; covers LATENCY up to 15
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/MEM pipeline stages, the arbiter and the memory file.
// slave = arbiter view, master = pipeline + memory view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);

  logic              FE_REQ;
  logic [ADDR_W-1:0] FE_ADDR;
  logic              FE_ACK;
  logic [31:0]       FE_DATA;
  logic              FE_STALL;

  logic              MEM_REQ;
  logic              MEM_R_W;
  logic [2:0]        MEM_SIZE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_WDATA;
  logic              MEM_ACK;
  logic [DATA_W-1:0] MEM_RDATA;
  logic              MEM_STALL;

  logic              MF_V;
  logic              MF_R_W;
  logic [2:0]        MF_SIZE;
  logic [ADDR_W-1:0] MF_ADDR;
  logic [DATA_W-1:0] MF_DATA_IN;
  logic [DATA_W-1:0] MF_DATA_OUT;

  modport slave (
    input  FE_REQ, FE_ADDR,
    output FE_ACK, FE_DATA, FE_STALL,
    input  MEM_REQ, MEM_R_W, MEM_SIZE, MEM_ADDR, MEM_WDATA,
    output MEM_ACK, MEM_RDATA, MEM_STALL,
    output MF_V, MF_R_W, MF_SIZE, MF_ADDR, MF_DATA_IN,
    input  MF_DATA_OUT
  );

  modport master (
    output FE_REQ, FE_ADDR,
    input  FE_ACK, FE_DATA, FE_STALL,
    output MEM_REQ, MEM_R_W, MEM_SIZE, MEM_ADDR, MEM_WDATA,
    input  MEM_ACK, MEM_RDATA, MEM_STALL,
    input  MF_V, MF_R_W, MF_SIZE, MF_ADDR, MF_DATA_IN,
    output MF_DATA_OUT
  );

endinterface

// File: rtl/mem_arb_select.sv
// Winner selection between fetch and MEM requests.
// MEM_ARB_RR_EN: round-robin on contention; otherwise MEM has fixed priority.
module mem_arb_select
  import mem_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_win_c
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    o_win_c = i_req[REQ_MEM] ? REQ_MEM : REQ_FE;
    // On contention the requester that was not served last goes next
    if (i_req[REQ_FE] && i_req[REQ_MEM]) o_win_c = ~i_last;
  end
`else
  logic w_unused;
  assign w_unused = ^{i_last, i_req[REQ_FE]};

  always_comb begin
    o_win_c = i_req[REQ_MEM] ? REQ_MEM : REQ_FE;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported data memory between fetch and MEM stage, one access in flight.
// Optional macro MEM_ARB_RR_EN selects round-robin arbitration instead of fixed MEM priority.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64
) (
  input  logic               CLK,
  input  logic               RESET,
  mem_port_arbiter_if.slave  bus
);

  localparam int unsigned FE_W = 32;

  state_t              r_state,    w_state_nxt;
  logic [CNT_W-1:0]    r_cnt,      w_cnt_nxt;
  logic                r_id,       w_id_nxt;
  logic [ADDR_W-1:0]   r_addr,     w_addr_nxt;
  logic [2:0]          r_size,     w_size_nxt;
  logic                r_rw,       w_rw_nxt;
  logic [DATA_W-1:0]   r_wdata,    w_wdata_nxt;
  logic                r_mf_v,     w_mf_v_nxt;
  logic                r_mf_r_w,   w_mf_r_w_nxt;
  logic                r_fe_ack,   w_fe_ack_nxt;
  logic                r_mem_ack,  w_mem_ack_nxt;
  logic [FE_W-1:0]     r_fe_data,  w_fe_data_nxt;
  logic [DATA_W-1:0]   r_mem_rdata, w_mem_rdata_nxt;

  logic w_win;
  logic w_last;

  mem_arb_select u_sel (
    .i_req   ({bus.MEM_REQ, bus.FE_REQ}),
    .i_last  (w_last),
    .o_win_c (w_win)
  );

`ifdef MEM_ARB_RR_EN
  logic r_last;
  logic w_grant;

  assign w_grant = (r_state == IDLE) && (bus.FE_REQ || bus.MEM_REQ);

  always_ff @(posedge CLK) begin
    if (RESET)        r_last <= REQ_FE;
    else if (w_grant) r_last <= w_win;
  end

  assign w_last = r_last;
`else
  assign w_last = REQ_FE;
`endif

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_id_nxt        = r_id;
    w_addr_nxt      = r_addr;
    w_size_nxt      = r_size;
    w_rw_nxt        = r_rw;
    w_wdata_nxt     = r_wdata;
    w_mf_v_nxt      = 1'b0;
    w_mf_r_w_nxt    = 1'b0;
    w_fe_ack_nxt    = 1'b0;
    w_mem_ack_nxt   = 1'b0;
    w_fe_data_nxt   = r_fe_data;
    w_mem_rdata_nxt = r_mem_rdata;

    unique case (r_state)
      IDLE: begin
        if (bus.FE_REQ || bus.MEM_REQ) begin
          w_id_nxt = w_win;
          if (w_win == REQ_MEM) begin
            w_addr_nxt  = bus.MEM_ADDR;
            w_size_nxt  = bus.MEM_SIZE;
            w_rw_nxt    = bus.MEM_R_W;
            w_wdata_nxt = bus.MEM_WDATA;
          end else begin
            w_addr_nxt  = bus.FE_ADDR;
            w_size_nxt  = SZ_W;
            w_rw_nxt    = R_W_READ;
            w_wdata_nxt = '0;
          end
          w_cnt_nxt    = CNT_W'(LATENCY - 1);
          w_mf_v_nxt   = 1'b1;
          // Single-cycle access: the first ACCESS cycle is also the last
          w_mf_r_w_nxt = (w_rw_nxt == R_W_WRITE) && (LATENCY == 1);
          w_state_nxt  = ACCESS;
        end
      end
      ACCESS: begin
        if (r_cnt == '0) begin
          w_state_nxt = RESP;
          if (r_id == REQ_MEM) begin
            w_mem_ack_nxt   = 1'b1;
            w_mem_rdata_nxt = bus.MF_DATA_OUT;
          end else begin
            w_fe_ack_nxt  = 1'b1;
            w_fe_data_nxt = bus.MF_DATA_OUT[FE_W-1:0];
          end
        end else begin
          w_cnt_nxt    = r_cnt - CNT_W'(1);
          w_mf_v_nxt   = 1'b1;
          w_mf_r_w_nxt = (r_rw == R_W_WRITE) && (r_cnt == CNT_W'(1));
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_id        <= REQ_FE;
      r_addr      <= '0;
      r_size      <= '0;
      r_rw        <= R_W_READ;
      r_wdata     <= '0;
      r_mf_v      <= 1'b0;
      r_mf_r_w    <= 1'b0;
      r_fe_ack    <= 1'b0;
      r_mem_ack   <= 1'b0;
      r_fe_data   <= '0;
      r_mem_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_id        <= w_id_nxt;
      r_addr      <= w_addr_nxt;
      r_size      <= w_size_nxt;
      r_rw        <= w_rw_nxt;
      r_wdata     <= w_wdata_nxt;
      r_mf_v      <= w_mf_v_nxt;
      r_mf_r_w    <= w_mf_r_w_nxt;
      r_fe_ack    <= w_fe_ack_nxt;
      r_mem_ack   <= w_mem_ack_nxt;
      r_fe_data   <= w_fe_data_nxt;
      r_mem_rdata <= w_mem_rdata_nxt;
    end
  end

  assign bus.MF_V       = r_mf_v;
  assign bus.MF_R_W     = r_mf_r_w;
  assign bus.MF_SIZE    = r_size;
  assign bus.MF_ADDR    = r_addr;
  assign bus.MF_DATA_IN = r_wdata;
  assign bus.FE_ACK     = r_fe_ack;
  assign bus.FE_DATA    = r_fe_data;
  assign bus.MEM_ACK    = r_mem_ack;
  assign bus.MEM_RDATA  = r_mem_rdata;

  // Stalls follow the live requests so the pipeline releases in the ACK cycle
  assign bus.FE_STALL  = bus.FE_REQ  && !r_fe_ack;
  assign bus.MEM_STALL = bus.MEM_REQ && !r_mem_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: two random requesters plus a memory, checked
// against a transaction timeline model (grant at t, access t+1..t+L, ack at t+L+1).
module tb_mem_port_arbiter;
  import mem_pkg::*;

  localparam int LAT  = 2;
  localparam int NCYC = 4000;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  mem_port_arbiter #(.LATENCY(LAT), .ADDR_W(64), .DATA_W(64)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, act, exp);
    end
  endtask

  // Memory seen by the DUT (written from its pins) and the model's own memory
  logic [63:0] tb_mem  [logic [63:0]];
  logic [63:0] ref_mem [logic [63:0]];

  function automatic logic [63:0] init_val(input logic [63:0] a);
    return {~a[31:0], a[31:0] ^ 32'h5A5A_0013};
  endfunction

  function automatic logic [63:0] tb_rd(input logic [63:0] a);
    if (tb_mem.exists(a)) return tb_mem[a];
    return init_val(a);
  endfunction

  function automatic logic [63:0] ref_rd(input logic [63:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  function automatic logic [63:0] rand_addr();
    return 64'h100 + 64'(8 * $urandom_range(0, 7));
  endfunction

  // Model: one outstanding transaction described by its grant cycle
  bit          g_valid = 1'b0;
  int          g_cyc   = 0;
  logic        g_id    = REQ_FE;
  logic        g_rw    = 1'b0;
  logic [2:0]  g_size  = '0;
  logic [63:0] g_addr  = '0;
  logic [63:0] g_wdata = '0;
  logic [63:0] g_rdata = '0;
  int          next_free = 0;
  logic [31:0] exp_fe  = '0;
  logic [63:0] exp_mem = '0;
`ifdef MEM_ARB_RR_EN
  logic        last_g  = REQ_FE;
`endif

  // Requester state
  bit          fe_busy = 0, fe_drop = 0, fe_ackd = 0;
  logic [63:0] fe_addr = '0;
  bit          mem_busy = 0, mem_drop = 0, mem_ackd = 0;
  logic [63:0] mem_addr = '0, mem_wdata = '0;
  logic        mem_rw = 1'b0;
  logic [2:0]  mem_size = '0;

  initial begin
    bit   in_acc, fin, fe_ack_e, mem_ack_e, do_rst, fe_req, mem_req;
    logic win;

    RESET           = 1'b1;
    bus.FE_REQ      = 1'b0;
    bus.FE_ADDR     = '0;
    bus.MEM_REQ     = 1'b0;
    bus.MEM_R_W     = 1'b0;
    bus.MEM_SIZE    = '0;
    bus.MEM_ADDR    = '0;
    bus.MEM_WDATA   = '0;
    bus.MF_DATA_OUT = '0;
    repeat (3) @(negedge CLK);

    check_val("rst_MF_V",      64'(bus.MF_V),      64'd0);
    check_val("rst_MF_R_W",    64'(bus.MF_R_W),    64'd0);
    check_val("rst_MF_SIZE",   64'(bus.MF_SIZE),   64'd0);
    check_val("rst_MF_ADDR",   bus.MF_ADDR,        64'd0);
    check_val("rst_MF_DATA_IN", bus.MF_DATA_IN,    64'd0);
    check_val("rst_FE_ACK",    64'(bus.FE_ACK),    64'd0);
    check_val("rst_FE_DATA",   64'(bus.FE_DATA),   64'd0);
    check_val("rst_MEM_ACK",   64'(bus.MEM_ACK),   64'd0);
    check_val("rst_MEM_RDATA", bus.MEM_RDATA,      64'd0);
    check_val("rst_FE_STALL",  64'(bus.FE_STALL),  64'd0);
    check_val("rst_MEM_STALL", 64'(bus.MEM_STALL), 64'd0);

    for (int it = 0; it < NCYC; it++) begin
      @(negedge CLK);
      cyc++;

      // Expected activity for this cycle from the outstanding transaction
      in_acc    = g_valid && (cyc > g_cyc) && (cyc <= g_cyc + LAT);
      fin       = g_valid && (cyc == g_cyc + LAT + 1);
      fe_ack_e  = fin && (g_id == REQ_FE);
      mem_ack_e = fin && (g_id == REQ_MEM);

      if (bus.MF_V && bus.MF_R_W) tb_mem[bus.MF_ADDR] = bus.MF_DATA_IN;
      if (in_acc && (cyc == g_cyc + LAT)) begin
        if (g_rw) ref_mem[g_addr] = g_wdata;
        g_rdata = ref_rd(g_addr);
      end
      if (mem_ack_e) exp_mem = g_rdata;
      if (fe_ack_e)  exp_fe  = g_rdata[31:0];

      check_val("MF_V",   64'(bus.MF_V),   64'(in_acc));
      check_val("MF_R_W", 64'(bus.MF_R_W), 64'(in_acc && g_rw && (cyc == g_cyc + LAT)));
      if (in_acc) begin
        check_val("MF_ADDR", bus.MF_ADDR,      g_addr);
        check_val("MF_SIZE", 64'(bus.MF_SIZE), 64'(g_size));
        if (g_rw) check_val("MF_DATA_IN", bus.MF_DATA_IN, g_wdata);
      end
      check_val("FE_ACK",    64'(bus.FE_ACK),  64'(fe_ack_e));
      check_val("MEM_ACK",   64'(bus.MEM_ACK), 64'(mem_ack_e));
      check_val("FE_DATA",   64'(bus.FE_DATA), 64'(exp_fe));
      check_val("MEM_RDATA", bus.MEM_RDATA,    exp_mem);

      if (fin) begin
        g_valid = 1'b0;
        if (fe_ack_e)  fe_ackd  = 1;
        if (mem_ack_e) mem_ackd = 1;
      end

      // Occasional reset while an access is outstanding
      do_rst = g_valid && ($urandom_range(0, 59) == 0);
      if (do_rst) begin
        g_valid = 1'b0;
        fe_busy = 0;  fe_drop = 0;  fe_ackd = 0;
        mem_busy = 0; mem_drop = 0; mem_ackd = 0;
        exp_fe  = '0;
        exp_mem = '0;
`ifdef MEM_ARB_RR_EN
        last_g = REQ_FE;
`endif
      end else begin
        // Requests are held through the ACK cycle and released the cycle after
        if (fe_ackd && !fe_ack_e)   begin fe_busy = 0;  fe_drop = 0;  fe_ackd = 0;  end
        if (mem_ackd && !mem_ack_e) begin mem_busy = 0; mem_drop = 0; mem_ackd = 0; end
        if (!fe_busy && ($urandom_range(0, 2) == 0)) begin
          fe_busy = 1;
          fe_addr = rand_addr();
        end
        if (!mem_busy && ($urandom_range(0, 2) == 0)) begin
          mem_busy  = 1;
          mem_addr  = rand_addr();
          mem_rw    = 1'($urandom_range(0, 1));
          mem_size  = 3'($urandom_range(0, 3));
          mem_wdata = {$urandom, $urandom};
        end
        // A granted requester may abandon its request; the access still completes
        if (g_valid && fe_busy && (g_id == REQ_FE) && ($urandom_range(0, 19) == 0))  fe_drop = 1;
        if (g_valid && mem_busy && (g_id == REQ_MEM) && ($urandom_range(0, 19) == 0)) mem_drop = 1;
      end

      fe_req  = fe_busy && !fe_drop;
      mem_req = mem_busy && !mem_drop;
      RESET         = do_rst;
      bus.FE_REQ    = fe_req;
      bus.FE_ADDR   = fe_addr;
      bus.MEM_REQ   = mem_req;
      bus.MEM_R_W   = mem_rw;
      bus.MEM_SIZE  = mem_size;
      bus.MEM_ADDR  = mem_addr;
      bus.MEM_WDATA = mem_wdata;
      bus.MF_DATA_OUT = tb_rd(bus.MF_ADDR);
      #1;
      check_val("FE_STALL",  64'(bus.FE_STALL),  64'(fe_req && !fe_ack_e));
      check_val("MEM_STALL", 64'(bus.MEM_STALL), 64'(mem_req && !mem_ack_e));

      // Grant decision for this cycle
      if (do_rst) begin
        next_free = cyc + 1;
      end else if (!g_valid && (cyc >= next_free) && (fe_req || mem_req)) begin
        if (fe_req && mem_req) begin
`ifdef MEM_ARB_RR_EN
          win = (last_g == REQ_MEM) ? REQ_FE : REQ_MEM;
`else
          win = REQ_MEM;
`endif
        end else begin
          win = mem_req ? REQ_MEM : REQ_FE;
        end
`ifdef MEM_ARB_RR_EN
        last_g = win;
`endif
        g_valid   = 1'b1;
        g_cyc     = cyc;
        g_id      = win;
        next_free = cyc + LAT + 2;
        if (win == REQ_MEM) begin
          g_addr  = mem_addr;
          g_size  = mem_size;
          g_rw    = mem_rw;
          g_wdata = mem_wdata;
        end else begin
          g_addr  = fe_addr;
          g_size  = SZ_W;
          g_rw    = R_W_READ;
          g_wdata = '0;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
